// File: rtl/gf163_pkg.sv
// ---------------------------------------------------------------------------
// gf163_pkg : GF(2^163) shared constants, field polynomial taps, FSM states
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package gf163_pkg;

  localparam int M      = 163;
  localparam int PROD_W = 2*M - 1;
  localparam int NTAPS  = 4;

  // Exponents of f(x) = x^163 + x^7 + x^6 + x^3 + 1, excluding the leading term
  localparam int FPOLY_TAPS [NTAPS] = '{7, 6, 3, 0};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REDUCE = 2'd1,
    DONE   = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/gf163_fold_digit.sv
// ---------------------------------------------------------------------------
// gf163_fold_digit : folds one DIGIT-wide slice of the working word into f(x)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module gf163_fold_digit
  import gf163_pkg::*;
#(
  parameter int DIGIT  = 8,
  parameter int NCYC   = (M - 1 + DIGIT - 1) / DIGIT,
  parameter int CNT_W  = $clog2(NCYC + 1),
  parameter int WORK_W = M + NCYC * DIGIT
) (
  input  logic [WORK_W-1:0] w_in,
  input  logic [CNT_W-1:0]  digit_idx,
  output logic [WORK_W-1:0] w_out
);

  logic [DIGIT-1:0]  w_digit;
  logic [WORK_W-1:0] w_ext;
  int                w_lo;

  // Indices past the last digit pass the word through untouched
  always_comb begin
    w_out   = w_in;
    w_digit = '0;
    w_ext   = '0;
    w_lo    = 0;
    if (int'(digit_idx) < NCYC) begin
      w_lo    = (NCYC - 1 - int'(digit_idx)) * DIGIT;
      w_digit = w_in[w_lo + M +: DIGIT];
      w_ext   = WORK_W'(w_digit);
      w_out[w_lo + M +: DIGIT] = '0;
      for (int t = 0; t < NTAPS; t++) begin
        w_out = w_out ^ (w_ext << (w_lo + FPOLY_TAPS[t]));
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/gf163_reduce.sv
// ---------------------------------------------------------------------------
// gf163_reduce : digit-serial reduction of a 325-bit product modulo f(x)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module gf163_reduce
  import gf163_pkg::*;
#(
  parameter int DIGIT = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_c,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [M-1:0]      out_r,
  output logic              busy
);

  localparam int NCYC   = (M - 1 + DIGIT - 1) / DIGIT;
  localparam int CNT_W  = $clog2(NCYC + 1);
  localparam int WORK_W = M + NCYC * DIGIT;

  if (DIGIT < 1 || DIGIT > 16) begin : g_bad_digit
    $error("gf163_reduce: DIGIT must be within 1..16");
  end

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [WORK_W-1:0] r_w;
  logic [WORK_W-1:0] w_fold;

  gf163_fold_digit #(
    .DIGIT  (DIGIT),
    .NCYC   (NCYC),
    .CNT_W  (CNT_W),
    .WORK_W (WORK_W)
  ) u_fold (
    .w_in      (r_w),
    .digit_idx (r_cnt),
    .w_out     (w_fold)
  );

  // The last REDUCE cycle (count == NCYC) only latches the fully folded word
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_w       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_r     <= '0;
      busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_w      <= WORK_W'(in_c);
            r_cnt    <= '0;
            r_state  <= REDUCE;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        REDUCE: begin
          r_w   <= w_fold;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CNT_W'(NCYC)) begin
            out_r     <= r_w[M-1:0];
            out_valid <= 1'b1;
            r_state   <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
